serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, start/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_START,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_DIFF,
  output logic             o_BORROW,
  output logic             o_SBIT,
  output logic             o_SVALID
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    count;

  logic a0;
  logic b0;
  logic d;
  logic br_next;
  logic in_shift;

  // Single full-subtractor cell working on the operand LSBs and the stored borrow
  assign a0       = a_sr[0];
  assign b0       = b_sr[0];
  assign d        = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign in_shift = (state == S_SHIFT);

  // Serial stream is only meaningful in SHIFT; forced low otherwise
  assign o_SBIT   = in_shift & d;
  assign o_SVALID = in_shift;

  // Control FSM and datapath registers; result registers only update on the last bit
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state    <= S_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      br       <= 1'b0;
      count    <= '0;
      o_BUSY   <= 1'b0;
      o_DONE   <= 1'b0;
      o_DIFF   <= '0;
      o_BORROW <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          o_DONE <= 1'b0;
          if (i_START) begin
            a_sr   <= i_A;
            b_sr   <= i_B;
            d_sr   <= '0;
            br     <= 1'b0;
            count  <= '0;
            o_BUSY <= 1'b1;
            state  <= S_SHIFT;
          end else begin
            o_BUSY <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          d_sr  <= {d, d_sr[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          br    <= br_next;
          count <= count + CW'(1);
          if (count == LAST_BIT) begin
            o_DIFF   <= {d, d_sr[WIDTH-1:1]};
            o_BORROW <= br_next;
            o_DONE   <= 1'b1;
            o_BUSY   <= 1'b0;
            state    <= S_DONE;
          end
        end
        default: begin
          o_DONE <= 1'b0;
          o_BUSY <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
